gc_write_dispatch: RTL and testbench

- Write-side counterpart of the controller's 8-bank read-data select path.
- Accepts 64-bit write requests tagged with a 3-bit bank index through a valid/ready handshake and buffers them in a small in-order FIFO.
- Steers each word to the addressed gain-cell bank with a one-cycle write-enable pulse.
- Enforces a per-bank write-recovery window before that bank may be written again.

---
 rtl/gc_write_dispatch.sv | 113 +++++++++++
 tb/tb_gc_write_dispatch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_write_dispatch.sv
// Write dispatcher for the 8-bank gain-cell array: buffers bank-tagged write
// requests in order and pulses each bank's write enable once its recovery window has passed.
module gc_write_dispatch #(
    parameter int DATA_W     = 64,
    parameter int NUM_BANKS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_CYCLES  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [2:0]                          req_bank,
    input  logic [DATA_W-1:0]                   req_data,
    output logic [NUM_BANKS-1:0]                bank_we,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]    bank_wdata,
    output logic [NUM_BANKS-1:0]                bank_busy,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
    output logic                                idle
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BUSY_W = $clog2(WR_CYCLES + 1);

    logic [2:0]        q_bank [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [BUSY_W-1:0] cnt [NUM_BANKS];

    logic              push;
    logic              pop;
    logic [2:0]        head_bank;
    logic [DATA_W-1:0] head_data;

    always_comb begin
        req_ready = !rst && (fifo_count != CNT_W'(FIFO_DEPTH));
        push      = req_valid && req_ready;
        head_bank = q_bank[rd_ptr];
        head_data = q_data[rd_ptr];
        // Head-of-line blocking: only the oldest entry may ever issue.
        pop       = (fifo_count != '0) && !bank_busy[head_bank];
    end

    always_comb begin
        bank_busy = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_busy[b] = (cnt[b] != '0);
        end
    end

    assign idle = (fifo_count == '0) && (bank_busy == '0) && (bank_we == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_bank[wr_ptr] <= req_bank;
            q_data[wr_ptr] <= req_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_we    <= '0;
            bank_wdata <= '0;
        end else begin
            bank_we    <= '0;
            bank_wdata <= '0;
            if (pop) begin
                bank_we[head_bank]    <= 1'b1;
                bank_wdata[head_bank] <= head_data;
            end
        end
    end

    // Loading WR_CYCLES alongside the pulse keeps the bank busy for exactly that many cycles.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (rst) begin
                cnt[b] <= '0;
            end else if (pop && (head_bank == 3'(b))) begin
                cnt[b] <= BUSY_W'(WR_CYCLES);
            end else if (cnt[b] != '0) begin
                cnt[b] <= cnt[b] - 1'b1;
            end
        end
    end

    a_we_onehot: assert property (@(posedge clk) $onehot0(bank_we));

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_chk
        a_we_not_busy: assert property (@(posedge clk) disable iff (rst)
            bank_we[g] |-> !$past(bank_busy[g]));
    end

endmodule

// File: tb/tb_gc_write_dispatch.sv
// Directed bench for gc_write_dispatch: reset, latency, streaming, same-bank
// blocking, full/wrap, mid-operation reset and simultaneous push/pop.
module tb_gc_write_dispatch;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_bank;
    logic [63:0]     req_data;
    logic [7:0]      bank_we;
    logic [7:0][63:0] bank_wdata;
    logic [7:0]      bank_busy;
    logic [2:0]      fifo_count;
    logic            idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gc_write_dispatch #(
        .DATA_W(64),
        .NUM_BANKS(8),
        .FIFO_DEPTH(4),
        .WR_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_bank(req_bank),
        .req_data(req_data),
        .bank_we(bank_we),
        .bank_wdata(bank_wdata),
        .bank_busy(bank_busy),
        .fifo_count(fifo_count),
        .idle(idle)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_bank = '0; req_data = '0;
        step(); step();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
        checks++; if (bank_we !== 8'h00) begin errors++; $display("FAIL rst_we: got %h expected 00", bank_we); end
        checks++; if (bank_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", bank_wdata); end
        checks++; if (bank_busy !== 8'h00) begin errors++; $display("FAIL rst_busy: got %h expected 00", bank_busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_single();
        logic [7:0][63:0] exp_wd;
        exp_wd = '0;
        exp_wd[5] = 64'hDEAD_BEEF_0123_4567;
        req_valid = 1'b1; req_bank = 3'd5; req_data = 64'hDEAD_BEEF_0123_4567;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_a1: got %0d expected 1", fifo_count); end
        checks++; if (bank_we !== 8'h00) begin errors++; $display("FAIL single_we_a1: got %h expected 00", bank_we); end
        step();
        checks++; if (bank_we !== 8'h20) begin errors++; $display("FAIL single_we_a2: got %h expected 20", bank_we); end
        checks++; if (bank_wdata !== exp_wd) begin errors++; $display("FAIL single_wdata_a2: got %h expected %h", bank_wdata, exp_wd); end
        checks++; if (bank_busy !== 8'h20) begin errors++; $display("FAIL single_busy_a2: got %h expected 20", bank_busy); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_a2: got %b expected 0", idle); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_a2: got %0d expected 0", fifo_count); end
        step();
        checks++; if (bank_we !== 8'h00) begin errors++; $display("FAIL single_we_a3: got %h expected 00", bank_we); end
        checks++; if (bank_busy !== 8'h20) begin errors++; $display("FAIL single_busy_a3: got %h expected 20", bank_busy); end
        step();
        checks++; if (bank_busy !== 8'h20) begin errors++; $display("FAIL single_busy_a4: got %h expected 20", bank_busy); end
        checks++; if (bank_wdata !== '0) begin errors++; $display("FAIL single_wdata_a4: got %h expected 0", bank_wdata); end
        step();
        checks++; if (bank_busy !== 8'h00) begin errors++; $display("FAIL single_busy_a5: got %h expected 00", bank_busy); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_a5: got %b expected 1", idle); end
    endtask

    task automatic test_stream();
        logic [7:0]       exp_we;
        logic [7:0][63:0] exp_wd;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req_valid = 1'b1; req_bank = 3'(i); req_data = 64'(i + 1);
            end else begin
                req_valid = 1'b0;
            end
            exp_we = (i >= 2) ? 8'(1 << (i - 2)) : 8'h00;
            exp_wd = '0;
            if (i >= 2) exp_wd[i - 2] = 64'(i - 1);
            checks++; if (bank_we !== exp_we) begin errors++; $display("FAIL stream_we c%0d: got %h expected %h", i, bank_we, exp_we); end
            checks++; if (bank_wdata !== exp_wd) begin errors++; $display("FAIL stream_wdata c%0d: got %h expected %h", i, bank_wdata, exp_wd); end
            checks++; if (fifo_count > 3'd1) begin errors++; $display("FAIL stream_count c%0d: got %0d expected at most 1", i, fifo_count); end
            step();
        end
        step(); step();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL stream_idle: got %b expected 1", idle); end
    endtask

    task automatic test_same_bank();
        logic [7:0]       exp_we;
        logic [7:0][63:0] exp_wd;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 3);
            case (k)
                0: begin req_bank = 3'd2; req_data = 64'hA; end
                1: begin req_bank = 3'd2; req_data = 64'hB; end
                2: begin req_bank = 3'd7; req_data = 64'hC; end
                default: ;
            endcase
            exp_we = 8'h00;
            exp_wd = '0;
            case (k)
                2: begin exp_we = 8'h04; exp_wd[2] = 64'hA; end
                6: begin exp_we = 8'h04; exp_wd[2] = 64'hB; end
                7: begin exp_we = 8'h80; exp_wd[7] = 64'hC; end
                default: ;
            endcase
            if (k < 3) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL same_ready c%0d: got %b expected 1", k, req_ready); end
            end
            checks++; if (bank_we !== exp_we) begin errors++; $display("FAIL same_we c%0d: got %h expected %h", k, bank_we, exp_we); end
            checks++; if (bank_wdata !== exp_wd) begin errors++; $display("FAIL same_wdata c%0d: got %h expected %h", k, bank_wdata, exp_wd); end
            step();
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL same_idle: got %b expected 1", idle); end
    endtask

    task automatic test_full_wrap();
        logic [2:0]  tb_bank [7] = '{3'd4, 3'd4, 3'd1, 3'd4, 3'd6, 3'd0, 3'd4};
        logic [63:0] tb_data [7] = '{64'h44, 64'h100, 64'h101, 64'h102, 64'h103, 64'h104, 64'h105};
        logic [2:0]  ob_bank [8];
        logic [63:0] ob_data [8];
        int n = 0;
        int idx = 0;
        logic acc;
        for (int k = 0; k < 80; k++) begin
            if (bank_we != 8'h00 && n < 8) begin
                for (int b = 0; b < 8; b++) begin
                    if (bank_we[b]) begin ob_bank[n] = 3'(b); ob_data[n] = bank_wdata[b]; end
                end
                n++;
            end
            if (n == 7) break;
            req_valid = (idx < 7);
            if (idx < 7) begin req_bank = tb_bank[idx]; req_data = tb_data[idx]; end
            if (k <= 4) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready c%0d: got %b expected 1", k, req_ready); end
            end
            if (k == 1) begin
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL full_count c1: got %0d expected 1", fifo_count); end
            end
            if (k == 5) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready c5: got %b expected 0", req_ready); end
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count c5: got %0d expected 4", fifo_count); end
            end
            acc = req_valid && req_ready;
            step();
            if (acc) idx++;
        end
        req_valid = 1'b0;
        checks++; if (n != 7) begin errors++; $display("FAIL full_pulse_total: got %0d expected 7 within budget", n); end
        for (int i = 0; i < n && i < 7; i++) begin
            checks++;
            if (ob_bank[i] !== tb_bank[i] || ob_data[i] !== tb_data[i]) begin
                errors++;
                $display("FAIL full_order #%0d: got bank %0d data %h expected bank %0d data %h", i, ob_bank[i], ob_data[i], tb_bank[i], tb_data[i]);
            end
        end
        step(); step(); step(); step();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full_idle: got %b expected 1", idle); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            case (k)
                0: begin req_bank = 3'd4; req_data = 64'h4000; end
                1: begin req_bank = 3'd4; req_data = 64'h4001; end
                2: begin req_bank = 3'd2; req_data = 64'h2002; end
                default: begin req_bank = 3'd3; req_data = 64'h3003; end
            endcase
            step();
        end
        req_valid = 1'b0;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_count_pre: got %0d expected 3", fifo_count); end
        checks++; if (bank_busy !== 8'h10) begin errors++; $display("FAIL rmid_busy_pre: got %h expected 10", bank_busy); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %b expected 0", req_ready); end
        step();
        rst = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
        checks++; if (bank_busy !== 8'h00) begin errors++; $display("FAIL rmid_busy: got %h expected 00", bank_busy); end
        checks++; if (bank_we !== 8'h00) begin errors++; $display("FAIL rmid_we: got %h expected 00", bank_we); end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (bank_we !== 8'h00) begin errors++; $display("FAIL rmid_no_stale_we c%0d: got %h expected 00", k, bank_we); end
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rmid_idle: got %b expected 1", idle); end
    endtask

    task automatic test_simul_push_pop();
        int          cnt_tbl [10] = '{0, 1, 1, 2, 2, 2, 2, 1, 0, 0};
        logic [7:0]       exp_we;
        logic [7:0][63:0] exp_wd;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k <= 2) || (k == 5);
            case (k)
                0: begin req_bank = 3'd5; req_data = 64'h50; end
                1: begin req_bank = 3'd5; req_data = 64'h51; end
                2: begin req_bank = 3'd6; req_data = 64'h60; end
                5: begin req_bank = 3'd7; req_data = 64'h70; end
                default: ;
            endcase
            exp_we = 8'h00;
            exp_wd = '0;
            case (k)
                2: begin exp_we = 8'h20; exp_wd[5] = 64'h50; end
                6: begin exp_we = 8'h20; exp_wd[5] = 64'h51; end
                7: begin exp_we = 8'h40; exp_wd[6] = 64'h60; end
                8: begin exp_we = 8'h80; exp_wd[7] = 64'h70; end
                default: ;
            endcase
            checks++; if (fifo_count !== 3'(cnt_tbl[k])) begin errors++; $display("FAIL simul_count c%0d: got %0d expected %0d", k, fifo_count, cnt_tbl[k]); end
            checks++; if (bank_we !== exp_we) begin errors++; $display("FAIL simul_we c%0d: got %h expected %h", k, bank_we, exp_we); end
            checks++; if (bank_wdata !== exp_wd) begin errors++; $display("FAIL simul_wdata c%0d: got %h expected %h", k, bank_wdata, exp_wd); end
            step();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_same_bank();
        test_full_wrap();
        test_reset_mid();
        test_simul_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
